// File: rtl/eth_model_pkg.sv
// Shared types and helpers for the 10G MAC RX frame model.
package eth_model_pkg;

  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  seed;
    logic        bad;
  } rx_req_t;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StData = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam int unsigned StatLenW    = 14;
  localparam int unsigned StatGoodBit = 14;
  localparam int unsigned StatBadBit  = 15;
  localparam int unsigned StatW       = 30;

  // Byte enables for the final beat; a multiple of 8 bytes fills the whole beat.
  function automatic logic [7:0] last_keep(input logic [2:0] len_mod);
    logic [8:0] mask;
    mask = (9'd1 << len_mod) - 9'd1;
    return (len_mod == 3'd0) ? 8'hFF : mask[7:0];
  endfunction

endpackage

// File: rtl/eth_req_fifo.sv
// Frame request queue: synchronous FIFO of rx_req_t with synchronous active-low reset.
module eth_req_fifo
  import eth_model_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  rx_req_t         wdata_i,
  input  logic            pop_i,
  output rx_req_t         rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  rx_req_t         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i & ~full_o;
    pop_ok   = pop_i & ~empty_o;
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/eth_rx_frame_model.sv
// Simulation model of a 10G MAC receive path: queued frame requests become AXI-Stream
// beats with no backpressure, last-beat tkeep, tuser status and a statistics pulse.
module eth_rx_frame_model
  import eth_model_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_LEN    = 9600,
  parameter int unsigned IFG_CYCLES = 3
) (
  input  logic              coreclk,
  input  logic              rx_axis_aresetn,
  input  logic              rx_enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_len,
  input  logic [7:0]        req_seed,
  input  logic              req_bad,
  output logic [63:0]       m_axis_rx_tdata,
  output logic [7:0]        m_axis_rx_tkeep,
  output logic              m_axis_rx_tlast,
  output logic              m_axis_rx_tuser,
  output logic              m_axis_rx_tvalid,
  output logic              rx_statistics_valid,
  output logic [StatW-1:0]  rx_statistics_vector,
  output logic              busy
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GapMax = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
  localparam int unsigned GapW   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  rx_req_t         wr_req, head;
  logic            fifo_full, fifo_empty, push, pop;
  logic [CntW-1:0] fifo_count, cnt_next;

  logic [1:0]          state_q, state_d;
  logic [15:0]         rem_q, rem_d;
  logic [7:0]          byte_q, byte_d;
  logic [13:0]         len_q, len_d;
  logic                bad_q, bad_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic                req_ready_q, req_ready_d;
  logic [63:0]         tdata_q, tdata_d;
  logic [7:0]          tkeep_q, tkeep_d;
  logic                tlast_q, tlast_d, tuser_q, tuser_d, tvalid_q, tvalid_d;
  logic                stats_valid_q, stats_valid_d;
  logic [StatW-1:0]    stats_vec_q, stats_vec_d;

  assign push = req_valid & req_ready_q;

  always_comb begin
    wr_req.len  = (32'(req_len) > MAX_LEN) ? 16'(MAX_LEN) : req_len;
    wr_req.seed = req_seed;
    wr_req.bad  = req_bad;
  end

  eth_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (coreclk),
    .rst_ni  (rx_axis_aresetn),
    .push_i  (push),
    .wdata_i (wr_req),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Ready follows the post-edge occupancy, so space freed by a pop shows up a cycle later.
  always_comb begin
    cnt_next    = fifo_count + CntW'(push) - CntW'(pop);
    req_ready_d = (cnt_next < CntW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    byte_d   = byte_q;
    len_d    = len_q;
    bad_d    = bad_q;
    gap_d    = gap_q;
    pop      = 1'b0;
    tvalid_d = 1'b0;
    tdata_d  = '0;
    tkeep_d  = '0;
    tlast_d  = 1'b0;
    tuser_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx_enable && !fifo_empty) begin
          pop = 1'b1;
          // Zero-length entries are dropped here without a frame or gap.
          if (head.len != 16'd0) begin
            rem_d   = head.len;
            len_d   = head.len[13:0];
            byte_d  = head.seed;
            bad_d   = head.bad;
            state_d = StData;
          end
        end
      end
      StData: begin
        tvalid_d = 1'b1;
        if (rem_q <= 16'd8) begin
          tkeep_d = last_keep(len_q[2:0]);
          tlast_d = 1'b1;
          tuser_d = ~bad_q;
          gap_d   = '0;
          state_d = (IFG_CYCLES > 0) ? StGap : StIdle;
        end else begin
          tkeep_d = 8'hFF;
          rem_d   = rem_q - 16'd8;
          byte_d  = byte_q + 8'd8;
        end
        for (int unsigned b = 0; b < 8; b++) begin
          if (tkeep_d[b]) begin
            tdata_d[8*b +: 8] = byte_q + 8'(b);
          end
        end
      end
      StGap: begin
        if (gap_q == GapW'(GapMax)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // len_q/bad_q still describe the finished frame while tlast is on the bus.
  always_comb begin
    stats_valid_d = tlast_q;
    stats_vec_d   = '0;
    if (tlast_q) begin
      stats_vec_d[StatLenW-1:0] = len_q;
      stats_vec_d[StatGoodBit]  = ~bad_q;
      stats_vec_d[StatBadBit]   = bad_q;
    end
  end

  always_ff @(posedge coreclk) begin
    if (!rx_axis_aresetn) begin
      state_q       <= StIdle;
      rem_q         <= '0;
      byte_q        <= '0;
      len_q         <= '0;
      bad_q         <= 1'b0;
      gap_q         <= '0;
      req_ready_q   <= 1'b0;
      tdata_q       <= '0;
      tkeep_q       <= '0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      tvalid_q      <= 1'b0;
      stats_valid_q <= 1'b0;
      stats_vec_q   <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      byte_q        <= byte_d;
      len_q         <= len_d;
      bad_q         <= bad_d;
      gap_q         <= gap_d;
      req_ready_q   <= req_ready_d;
      tdata_q       <= tdata_d;
      tkeep_q       <= tkeep_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      tvalid_q      <= tvalid_d;
      stats_valid_q <= stats_valid_d;
      stats_vec_q   <= stats_vec_d;
    end
  end

  assign req_ready            = req_ready_q;
  assign m_axis_rx_tdata      = tdata_q;
  assign m_axis_rx_tkeep      = tkeep_q;
  assign m_axis_rx_tlast      = tlast_q;
  assign m_axis_rx_tuser      = tuser_q;
  assign m_axis_rx_tvalid     = tvalid_q;
  assign rx_statistics_valid  = stats_valid_q;
  assign rx_statistics_vector = stats_vec_q;
  assign busy = (state_q != StIdle) | ~fifo_empty | tvalid_q | fifo_full;

endmodule

// File: tb/tb_eth_rx_frame_model.sv
// Directed bench for eth_rx_frame_model: frame table plus reset, queue-full, zero-length
// and zero-gap sequences.
module tb_eth_rx_frame_model;

  logic        coreclk = 1'b0;
  logic        rstn, rx_enable;
  logic        req_valid, req_bad, req_ready;
  logic [15:0] req_len;
  logic [7:0]  req_seed;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tuser, tvalid, stv, busy;
  logic [29:0] stvec;

  logic        req_valid0, req_bad0, req_ready0;
  logic [15:0] req_len0;
  logic [7:0]  req_seed0;
  logic [63:0] tdata0;
  logic [7:0]  tkeep0;
  logic        tlast0, tuser0, tvalid0, stv0, busy0;
  logic [29:0] stvec0;

  always #5 coreclk = ~coreclk;

  eth_rx_frame_model #(.FIFO_DEPTH(4), .MAX_LEN(9600), .IFG_CYCLES(3)) dut (
    .coreclk(coreclk), .rx_axis_aresetn(rstn), .rx_enable(rx_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_seed(req_seed),
    .req_bad(req_bad), .m_axis_rx_tdata(tdata), .m_axis_rx_tkeep(tkeep),
    .m_axis_rx_tlast(tlast), .m_axis_rx_tuser(tuser), .m_axis_rx_tvalid(tvalid),
    .rx_statistics_valid(stv), .rx_statistics_vector(stvec), .busy(busy)
  );

  eth_rx_frame_model #(.FIFO_DEPTH(4), .MAX_LEN(9600), .IFG_CYCLES(0)) dut0 (
    .coreclk(coreclk), .rx_axis_aresetn(rstn), .rx_enable(rx_enable),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_len(req_len0),
    .req_seed(req_seed0), .req_bad(req_bad0), .m_axis_rx_tdata(tdata0),
    .m_axis_rx_tkeep(tkeep0), .m_axis_rx_tlast(tlast0), .m_axis_rx_tuser(tuser0),
    .m_axis_rx_tvalid(tvalid0), .rx_statistics_valid(stv0),
    .rx_statistics_vector(stvec0), .busy(busy0)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] len;
    logic [7:0]  seed;
    logic        bad;
    int          beats;
    logic [63:0] first;
    logic [7:0]  keep;
    logic        tuser;
    logic [29:0] stat;
  } vec_t;

  vec_t tbl[7];

  int          g_beats;
  logic [63:0] g_first;
  logic [7:0]  g_keep;
  logic        g_tuser, g_ok, g_sv;
  logic [29:0] g_vec;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic push(input logic [15:0] len, input logic [7:0] seed, input logic bad);
    req_valid = 1'b1; req_len = len; req_seed = seed; req_bad = bad;
    @(negedge coreclk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge coreclk);
      n++;
    end
    @(negedge coreclk);
    chk("idle_before_push", busy, 1'b0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!tvalid && lat < 60) begin
      @(negedge coreclk);
      lat++;
    end
  endtask

  // Walks one frame starting at its first beat and checks every byte against seed+index.
  task automatic get_frame(input int len_c, input logic [7:0] seed);
    g_beats = 0;
    g_ok = 1'b1;
    g_first = tdata;
    forever begin
      if (!tvalid) g_ok = 1'b0;
      for (int b = 0; b < 8; b++) begin
        int idx;
        logic [7:0] e;
        idx = g_beats * 8 + b;
        e = seed + 8'(idx);
        if (tkeep[b] !== (idx < len_c)) g_ok = 1'b0;
        if (idx < len_c && tdata[8*b +: 8] !== e) g_ok = 1'b0;
      end
      g_beats++;
      if (tlast === 1'b1 || g_beats > 1300 || !tvalid) break;
      if (tuser || stv) g_ok = 1'b0;
      @(negedge coreclk);
    end
    g_keep = tkeep;
    g_tuser = tuser;
    @(negedge coreclk);
    g_sv = stv;
    g_vec = stvec;
  endtask

  initial begin
    int lat, gap;
    logic seen;

    tbl[0] = '{16'd64,    8'h00, 1'b0, 8,    64'h0706050403020100, 8'hFF, 1'b1, 30'h4040};
    tbl[1] = '{16'd13,    8'hFA, 1'b1, 2,    64'h0100FFFEFDFCFBFA, 8'h1F, 1'b0, 30'h800D};
    tbl[2] = '{16'd20000, 8'h11, 1'b0, 1200, 64'h1817161514131211, 8'hFF, 1'b1, 30'h6580};
    tbl[3] = '{16'd1,     8'h55, 1'b0, 1,    64'h0000000000000055, 8'h01, 1'b1, 30'h4001};
    tbl[4] = '{16'd9,     8'hFF, 1'b1, 2,    64'h06050403020100FF, 8'h01, 1'b0, 30'h8009};
    tbl[5] = '{16'd9600,  8'h00, 1'b0, 1200, 64'h0706050403020100, 8'hFF, 1'b1, 30'h6580};
    tbl[6] = '{16'd15,    8'h80, 1'b0, 2,    64'h8786858483828180, 8'h7F, 1'b1, 30'h400F};

    rstn = 1'b0; rx_enable = 1'b0;
    req_valid = 1'b0; req_len = '0; req_seed = '0; req_bad = 1'b0;
    req_valid0 = 1'b0; req_len0 = '0; req_seed0 = '0; req_bad0 = 1'b0;
    repeat (3) @(negedge coreclk);
    chk("reset_ready", req_ready, 1'b0);
    chk("reset_tvalid", tvalid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_stats", {stv, stvec}, '0);
    rstn = 1'b1;
    @(negedge coreclk);
    chk("ready_after_release", req_ready, 1'b1);

    rx_enable = 1'b1;
    foreach (tbl[i]) begin
      int len_c;
      len_c = (tbl[i].len > 16'd9600) ? 9600 : int'(tbl[i].len);
      wait_idle();
      push(tbl[i].len, tbl[i].seed, tbl[i].bad);
      wait_valid(lat);
      chk($sformatf("t%0d_latency", i), lat, 2);
      get_frame(len_c, tbl[i].seed);
      chk($sformatf("t%0d_beats", i), g_beats, tbl[i].beats);
      chk($sformatf("t%0d_first", i), g_first, tbl[i].first);
      chk($sformatf("t%0d_keep", i), g_keep, tbl[i].keep);
      chk($sformatf("t%0d_tuser", i), g_tuser, tbl[i].tuser);
      chk($sformatf("t%0d_payload", i), g_ok, 1'b1);
      chk($sformatf("t%0d_stat_valid", i), g_sv, 1'b1);
      chk($sformatf("t%0d_stat_vec", i), g_vec, tbl[i].stat);
    end

    // Queue fill while disabled: four accepts, fifth refused.
    wait_idle();
    rx_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fill_ready_%0d", i), req_ready, (i < 4));
      push(16'd8, 8'(8'h10 * (i + 1)), 1'b0);
    end
    chk("full_ready", req_ready, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge coreclk);
      if (tvalid) seen = 1'b1;
    end
    chk("disabled_no_frame", seen, 1'b0);
    rx_enable = 1'b1;
    wait_valid(lat);
    for (int f = 0; f < 4; f++) begin
      if (f > 0) chk($sformatf("q%0d_gap", f), gap, 4);
      get_frame(8, 8'(8'h10 * (f + 1)));
      chk($sformatf("q%0d_seed", f), g_first[7:0], 8'(8'h10 * (f + 1)));
      chk($sformatf("q%0d_beats_ok", f), {g_ok, g_sv, 8'(g_beats)}, {2'b11, 8'd1});
      gap = 0;
      while (!tvalid && gap < 30) begin
        gap++;
        @(negedge coreclk);
      end
    end
    chk("no_fifth_frame", gap, 30);
    chk("fill_drained_busy", busy, 1'b0);

    // Zero-length entry is dropped with no gap penalty for the next frame.
    wait_idle();
    push(16'd0, 8'h99, 1'b0);
    push(16'd4, 8'h33, 1'b0);
    seen = stv;
    lat = 0;
    while (!tvalid && lat < 60) begin
      @(negedge coreclk);
      if (stv) seen = 1'b1;
      lat++;
    end
    chk("len0_no_stats", seen, 1'b0);
    chk("len0_next_latency", lat, 2);
    get_frame(4, 8'h33);
    chk("len0_next_first", g_first, 64'h0000000033343536 & 64'h0 | 64'h36353433);
    chk("len0_next_stat", g_vec, 30'h4004);

    // Reset during beat 3 of a 64-byte frame.
    wait_idle();
    push(16'd64, 8'h00, 1'b0);
    wait_valid(lat);
    repeat (3) @(negedge coreclk);
    chk("rst_beat3_data", tdata, 64'h1F1E1D1C1B1A1918);
    rstn = 1'b0;
    @(negedge coreclk);
    chk("rst_tvalid_drop", {tvalid, tlast}, 2'b00);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge coreclk);
      if (tvalid || tlast || stv) seen = 1'b1;
    end
    chk("rst_no_tail", seen, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 1'b1);

    // Zero-gap build: one idle cycle between frames.
    req_valid0 = 1'b1; req_len0 = 16'd16; req_seed0 = 8'h00; req_bad0 = 1'b0;
    @(negedge coreclk);
    req_seed0 = 8'h40;
    @(negedge coreclk);
    req_valid0 = 1'b0;
    lat = 0;
    while (!tlast0 && lat < 60) begin
      @(negedge coreclk);
      lat++;
    end
    chk("ifg0_tlast_seen", tlast0, 1'b1);
    @(negedge coreclk);
    gap = 0;
    while (!tvalid0 && gap < 60) begin
      gap++;
      @(negedge coreclk);
    end
    chk("ifg0_gap", gap, 1);
    chk("ifg0_f2_first", tdata0, 64'h4746454443424140);
    @(negedge coreclk);
    chk("ifg0_f2_last", {tlast0, tuser0, tkeep0}, {2'b11, 8'hFF});
    @(negedge coreclk);
    chk("ifg0_f2_stat", {stv0, stvec0}, {1'b1, 30'h4010});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
